// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 timer block: FSM states, write selects, widths.
package chip8_pkg;
  localparam int CLOCK_SPEED     = 25_000_000;
  localparam int TIMER_W_DEFAULT = 8;

  localparam logic WR_SEL_DT = 1'b0;
  localparam logic WR_SEL_ST = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    DEC  = 1'b1
  } timer_state_e;
endpackage

// File: rtl/cpu_timers_tone_gen.sv
// Square-wave buzzer: toggles every TONE_HALF_PERIOD cycles while enabled, low otherwise.
module tone_gen #(
  parameter int TONE_HALF_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tone
);
  localparam int CW = (TONE_HALF_PERIOD > 1) ? $clog2(TONE_HALF_PERIOD) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(TONE_HALF_PERIOD - 1);

  logic [CW-1:0] cnt;
  logic          armed;

  // One arming cycle after enable rises, so the first edge lands HALF_PERIOD+1 cycles later.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      cnt   <= RELOAD;
      armed <= 1'b0;
      tone  <= 1'b0;
    end else if (!armed) begin
      armed <= 1'b1;
    end else if (cnt == '0) begin
      tone <= ~tone;
      cnt  <= RELOAD;
    end else begin
      cnt <= cnt - CW'(1);
    end
  end
endmodule

// File: rtl/cpu_timers.sv
// CHIP-8 delay/sound timers: 60 Hz decrement pass arbitrated against CPU writes, plus buzzer.
module cpu_timers
  import chip8_pkg::*;
#(
  parameter int TONE_HALF_PERIOD = CLOCK_SPEED / 880,
  parameter int TIMER_W          = TIMER_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick_60hz,
  input  logic               paused,
  input  logic               wr_valid,
  input  logic               wr_sel,
  input  logic [TIMER_W-1:0] wr_data,
  output logic               wr_ready,
  output logic [TIMER_W-1:0] dt_value,
  output logic [TIMER_W-1:0] st_value,
  output logic               dt_zero,
  output logic               sound_active,
  output logic               tone,
  output logic               tick_overrun
);
  timer_state_e state;
  logic         tick_pending;
  logic         tick_in;

  assign tick_in      = tick_60hz && !paused;
  assign wr_ready     = (state == IDLE) && !rst;
  assign dt_zero      = (dt_value == '0);
  assign sound_active = (st_value != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      tick_pending <= 1'b0;
      dt_value     <= '0;
      st_value     <= '0;
      tick_overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Only one pending slot: a second tick before service is lost.
          if (tick_in && tick_pending) tick_overrun <= 1'b1;
          if (tick_in) tick_pending <= 1'b1;
          if (wr_valid) begin
            if (wr_sel == WR_SEL_ST) st_value <= wr_data;
            else                     dt_value <= wr_data;
          end else if ((tick_pending || tick_in) && !paused) begin
            state <= DEC;
          end
        end
        DEC: begin
          if (dt_value != '0) dt_value <= dt_value - TIMER_W'(1);
          if (st_value != '0) st_value <= st_value - TIMER_W'(1);
          tick_pending <= tick_in;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  tone_gen #(
    .TONE_HALF_PERIOD(TONE_HALF_PERIOD)
  ) u_tone (
    .clk   (clk),
    .rst   (rst),
    .enable(sound_active),
    .tone  (tone)
  );
endmodule

// File: tb/tb_cpu_timers.sv
// Directed bench for cpu_timers: per-cycle compare against a behavioural model plus literal pins.
module tb_cpu_timers;
  localparam int HP = 4;
  localparam int W  = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         tick_60hz = 1'b0;
  logic         paused = 1'b0;
  logic         wr_valid = 1'b0;
  logic         wr_sel = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         wr_ready;
  logic [W-1:0] dt_value;
  logic [W-1:0] st_value;
  logic         dt_zero;
  logic         sound_active;
  logic         tone;
  logic         tick_overrun;

  int tests = 0;
  int fails = 0;

  cpu_timers #(.TONE_HALF_PERIOD(HP), .TIMER_W(W)) dut (
    .clk(clk), .rst(rst), .tick_60hz(tick_60hz), .paused(paused),
    .wr_valid(wr_valid), .wr_sel(wr_sel), .wr_data(wr_data), .wr_ready(wr_ready),
    .dt_value(dt_value), .st_value(st_value), .dt_zero(dt_zero),
    .sound_active(sound_active), .tone(tone), .tick_overrun(tick_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: timer values, one served tick per decrement cycle, tone from rise time.
  int  m_dt, m_st, cyc, rise;
  bit  m_pend, m_dec, m_ovr, m_tone, prev_sa, m_valid, tk;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_dt = 0; m_st = 0; m_pend = 0; m_dec = 0; m_ovr = 0;
      m_tone = 0; prev_sa = 0; m_valid = 1;
    end else begin
      tk = tick_60hz && !paused;
      if (m_dec) begin
        m_dt   = (m_dt > 0) ? m_dt - 1 : 0;
        m_st   = (m_st > 0) ? m_st - 1 : 0;
        m_pend = tk;
        m_dec  = 0;
      end else begin
        if (tk && m_pend) m_ovr = 1;
        if (wr_valid) begin
          if (wr_sel) m_st = int'(wr_data);
          else        m_dt = int'(wr_data);
        end
        m_dec  = !wr_valid && (m_pend || tk) && !paused;
        m_pend = m_pend || tk;
      end
      m_tone = prev_sa ? (((cyc - rise - 1) / HP) % 2 == 1) : 1'b0;
      if (m_st != 0 && !prev_sa) rise = cyc;
      prev_sa = (m_st != 0);
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("wr_ready", int'(wr_ready), int'(!rst && !m_dec));
      chk("dt_value", int'(dt_value), m_dt);
      chk("st_value", int'(st_value), m_st);
      chk("dt_zero", int'(dt_zero), int'(m_dt == 0));
      chk("sound_active", int'(sound_active), int'(m_st != 0));
      chk("tone", int'(tone), int'(m_tone));
      chk("tick_overrun", int'(tick_overrun), int'(m_ovr));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic sel, input int val);
    wr_valid = 1'b1; wr_sel = sel; wr_data = W'(val);
    step(1);
    wr_valid = 1'b0;
  endtask

  task automatic tick1();
    tick_60hz = 1'b1;
    step(1);
    tick_60hz = 1'b0;
  endtask

  int before_v[4] = '{3, 2, 1, 0};
  int after_v[4]  = '{2, 1, 0, 0};

  initial begin
    // Reset state
    step(3);
    @(negedge clk); chk("lit_ready_in_rst", int'(wr_ready), 0);
    rst = 1'b0;
    step(1);
    @(negedge clk);
    chk("lit_ready_after_rst", int'(wr_ready), 1);
    chk("lit_dt_rst", int'(dt_value), 0);
    chk("lit_st_rst", int'(st_value), 0);
    chk("lit_dtz_rst", int'(dt_zero), 1);
    chk("lit_tone_rst", int'(tone), 0);

    // DT = 3 then ticks 20 cycles apart
    step(1);
    wr(1'b0, 3);
    @(negedge clk); chk("lit_dt_wr3", int'(dt_value), 3);
    for (int k = 0; k < 4; k++) begin
      tick1();
      @(negedge clk); chk("lit_dt_tick_n1", int'(dt_value), before_v[k]);
      step(1);
      @(negedge clk); chk("lit_dt_tick_n2", int'(dt_value), after_v[k]);
      step(18);
    end
    @(negedge clk); chk("lit_dtz_after", int'(dt_zero), 1);

    // Tick and write in the same cycle
    tick_60hz = 1'b1; wr_valid = 1'b1; wr_sel = 1'b0; wr_data = 8'd5;
    step(1);
    tick_60hz = 1'b0; wr_valid = 1'b0;
    @(negedge clk); chk("lit_dt5_n1", int'(dt_value), 5);
    step(2);
    @(negedge clk); chk("lit_dt4_n3", int'(dt_value), 4);
    chk("lit_no_overrun", int'(tick_overrun), 0);
    step(20);

    // Buzz with ST = 2, DT written mid-buzz
    wr(1'b1, 2);
    @(negedge clk); chk("lit_sa_rise", int'(sound_active), 1);
    chk("lit_tone_r0", int'(tone), 0);
    step(4); @(negedge clk); chk("lit_tone_r4", int'(tone), 0);
    step(1); @(negedge clk); chk("lit_tone_r5", int'(tone), 1);
    step(2);
    wr(1'b0, 9);
    step(1); @(negedge clk); chk("lit_tone_r9", int'(tone), 0);
    step(4); @(negedge clk); chk("lit_tone_r13", int'(tone), 1);
    tick1();
    step(20);
    tick1();
    step(1); @(negedge clk); chk("lit_st_zero", int'(st_value), 0);
    step(1); @(negedge clk); chk("lit_tone_off", int'(tone), 0);
    step(5);

    // Held write across two ticks -> overrun, single decrement afterwards
    wr_valid = 1'b1; wr_sel = 1'b0; wr_data = 8'd7; tick_60hz = 1'b1;
    step(1); tick_60hz = 1'b0;
    step(1); tick_60hz = 1'b1;
    step(1); tick_60hz = 1'b0; wr_valid = 1'b0;
    @(negedge clk); chk("lit_overrun", int'(tick_overrun), 1);
    chk("lit_dt7", int'(dt_value), 7);
    step(2); @(negedge clk); chk("lit_dt6", int'(dt_value), 6);
    step(10); @(negedge clk); chk("lit_dt6_hold", int'(dt_value), 6);

    // Paused ticks are dropped
    wr(1'b0, 10);
    paused = 1'b1;
    repeat (5) begin
      tick1();
      step(2);
    end
    @(negedge clk); chk("lit_dt10_paused", int'(dt_value), 10);
    paused = 1'b0;
    step(10); @(negedge clk); chk("lit_dt10_unpaused", int'(dt_value), 10);
    tick1();
    step(1); @(negedge clk); chk("lit_dt9", int'(dt_value), 9);
    step(3);

    // Reset during the decrement cycle
    wr(1'b0, 8);
    tick1();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("lit_dt_rst_dec", int'(dt_value), 0);
    chk("lit_ovr_rst_dec", int'(tick_overrun), 0);
    chk("lit_ready_rst_dec", int'(wr_ready), 1);
    step(5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cpu_timers.md
# cpu_timers

CHIP-8 delay timer (DT) and sound timer (ST) controller. Consumes the 60 Hz tick strobe from the system timer and sequences one decrement pass per tick. Arbitrates that decrement against CPU writes (FX15/FX18) and serves CPU reads (FX07). Drives the buzzer with a square-wave tone while ST is non-zero.

## Interface
Parameters:
- TONE_HALF_PERIOD, default `CLOCK_SPEED/880`, clk cycles per tone half-period (440 Hz); minimum 1
- TIMER_W, default 8, DT/ST width

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- tick_60hz  in  1  one-cycle strobe from the system timer's 60 Hz output
- paused  in  1  freeze: ticks neither latched nor served while high
- wr_valid  in  1  CPU write request
- wr_sel  in  1  0 = DT, 1 = ST
- wr_data  in  TIMER_W  value to load
- wr_ready  out  1  write can be accepted this cycle
- dt_value  out  TIMER_W  current DT (FX07 read)
- st_value  out  TIMER_W  current ST
- dt_zero  out  1  dt_value == 0
- sound_active  out  1  st_value != 0
- tone  out  1  buzzer square wave
- tick_overrun  out  1  sticky: a tick was lost

## Operation
- FSM states: IDLE, DEC. Reset → IDLE.
- tick_pending flag: set when tick_60hz && !paused; cleared when DEC executes. Set wins over clear in the same cycle.
- IDLE:
  - wr_ready = 1.
  - If wr_valid: load wr_data into the selected register and stay in IDLE. Writes have priority over decrement.
  - Else if (tick_pending || (tick_60hz && !paused)) && !paused: go to DEC.
- DEC (one cycle):
  - wr_ready = 0.
  - DT decrements if non-zero; ST decrements if non-zero. Both saturate at 0 and never wrap.
  - Clears tick_pending unless a new tick arrives this cycle.
  - Returns to IDLE.
- Overrun: tick_60hz && !paused while tick_pending is already set and not being cleared this cycle → tick_overrun = 1, held until rst. The lost tick is dropped; there is no second pending slot.
- paused high in IDLE: no DEC entry. A pending tick is held until paused falls.
- Tone generator:
  - While sound_active: half-period counter counts down from TONE_HALF_PERIOD-1; tone toggles at 0 and the counter reloads.
  - While !sound_active: counter is held at reload and tone = 0.
- Writing ST = 0 silences the buzzer on the next cycle.
- Writing DT or ST during a buzz does not restart the tone phase.

## Timing
- Reset values: dt_value = 0, st_value = 0, dt_zero = 1, sound_active = 0, tone = 0, tick_overrun = 0, state = IDLE, tick_pending = 0.
- wr_ready is 0 while rst is high and 1 on the first cycle after.
- Write accepted at cycle N → new value on dt_value/st_value at N+1.
- Tick at N, IDLE, no write → DEC at N+1 → decremented value visible at N+2.
- Tick and write at N → write visible at N+1, DEC at N+2, written value minus 1 at N+3.
- Write at N while in DEC (wr_ready = 0): not accepted. The CPU holds wr_valid; the write is taken at N+1.
- rst mid-DEC: rst wins. All state returns to reset values next cycle.
- sound_active rises at N → first tone edge at N + 1 + TONE_HALF_PERIOD.

## Structure
- Shared package chip8_pkg holds:
  - state enum (IDLE, DEC)
  - WR_SEL_DT = 0, WR_SEL_ST = 1
  - TIMER_W default
- Sub-module tone_gen:
  - inputs: clk, rst, enable (= sound_active)
  - output: tone
  - parameter: TONE_HALF_PERIOD
- The FSM, tick_pending and registers stay in cpu_timers.

## Test plan
- Reset then idle → dt_value = 0, st_value = 0, dt_zero = 1, tone = 0, wr_ready = 1.
- Write DT = 3, then 3 ticks 20 cycles apart → dt_value reads 3, 2, 1, 0, each change 2 cycles after its tick; a 4th tick leaves it at 0 and dt_zero = 1.
- Tick and DT = 5 write in the same cycle → dt_value = 5 at N+1 and 4 at N+3; tick_overrun stays 0.
- Write ST = 2 with TONE_HALF_PERIOD = 4 → tone toggles every 4 cycles after sound_active rises; after 2 ticks st_value = 0 and tone = 0 the following cycle.
- Hold wr_valid for 3 cycles while ticks arrive on 2 of them → second tick sets tick_overrun = 1; one decrement occurs after wr_valid drops.
- paused = 1 with 5 ticks, DT = 10 → dt_value stays 10. After paused falls, no decrement occurs until the next tick, which yields 9.
